datamem_responder: RTL and testbench

DATAMEM_RESPONDER -- requirements
Module: datamem_responder

---
 rtl/datamem_if.sv | 22 ++
 rtl/datamem_responder.sv | 99 +++++++++
 tb/tb_datamem_responder.sv | 148 ++++++++++++++
 3 files changed

// File: rtl/datamem_if.sv
// datamem_if: request/response bus between an initiator and the data memory responder
interface datamem_if;
    logic        req_valid;
    logic        req_ready;
    logic [63:0] address;
    logic        write_enable;
    logic        read_enable;
    logic [63:0] write_data;
    logic [3:0]  xfer_size;
    logic        resp_valid;
    logic        resp_ready;
    logic [63:0] read_data;
    logic        err;
    modport master (
        output req_valid, address, write_enable, read_enable, write_data, xfer_size, resp_ready,
        input  req_ready, resp_valid, read_data, err
    );
    modport slave (
        input  req_valid, address, write_enable, read_enable, write_data, xfer_size, resp_ready,
        output req_ready, resp_valid, read_data, err
    );
endinterface

// File: rtl/datamem_responder.sv
// datamem_responder: single-outstanding byte-addressed data memory with fixed response latency; DATAMEM_ALIGN_CHECK_EN adds a misalignment error check
module datamem_responder #(
    parameter int LATENCY     = 2,
    parameter int DEPTH_BYTES = 1024
) (
    input logic      clk,
    input logic      rst,
    datamem_if.slave bus
);
    localparam int AW = DEPTH_BYTES > 1 ? $clog2(DEPTH_BYTES) : 1;
    localparam logic [3:0] LAST = 4'(LATENCY > 1 ? LATENCY - 2 : 0);
    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
    state_t state, state_n;
    logic [3:0] cnt, cnt_n;
    logic [63:0] addr_q, wd_q, rd_q, rd_n;
    logic we_q, re_q, err_q;
    logic [3:0] xs_q;
    logic [7:0] mem [DEPTH_BYTES];
    logic accept, go_resp, w, r, size_ok, range_ok, align_ok, bad;
    logic [63:0] a, d;
    logic [3:0] s;
    logic [AW-1:0] base;
    // Access operands come straight from the bus on the accept edge (LATENCY=1), else from the capture registers
    always_comb begin
        accept   = state == IDLE && bus.req_valid;
        a        = accept ? bus.address : addr_q;
        d        = accept ? bus.write_data : wd_q;
        w        = accept ? bus.write_enable : we_q;
        r        = accept ? bus.read_enable : re_q;
        s        = accept ? bus.xfer_size : xs_q;
        size_ok  = s == 4'd1 || s == 4'd2 || s == 4'd4 || s == 4'd8;
        range_ok = {1'b0, a} + 65'(s) <= 65'(DEPTH_BYTES);
`ifdef DATAMEM_ALIGN_CHECK_EN
        align_ok = (a[3:0] & (s - 4'd1)) == 4'd0;
`else
        align_ok = 1'b1;
`endif
        bad      = !size_ok || !range_ok || !align_ok || (w && r);
        base     = a[AW-1:0];
        rd_n     = '0;
        for (int i = 0; i < 8; i++)
            if (r && !bad && i < int'(s)) rd_n[8*i +: 8] = mem[base + AW'(i)];
    end
    // Next-state: IDLE accepts, WAIT counts LATENCY-1 cycles, RESP holds until consumed
    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        go_resp = 1'b0;
        if (accept) begin
            state_n = LATENCY == 1 ? RESP : WAIT;
            cnt_n   = '0;
            go_resp = LATENCY == 1;
        end else if (state == WAIT) begin
            cnt_n   = cnt == LAST ? 4'd0 : cnt + 4'd1;
            state_n = cnt == LAST ? RESP : WAIT;
            go_resp = cnt == LAST;
        end else if (state == RESP && bus.resp_ready) begin
            state_n = IDLE;
        end
    end
    // State, request capture and registered response
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state  <= IDLE;
            cnt    <= '0;
            addr_q <= '0;
            wd_q   <= '0;
            we_q   <= 1'b0;
            re_q   <= 1'b0;
            xs_q   <= '0;
            rd_q   <= '0;
            err_q  <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                addr_q <= bus.address;
                wd_q   <= bus.write_data;
                we_q   <= bus.write_enable;
                re_q   <= bus.read_enable;
                xs_q   <= bus.xfer_size;
            end
            if (go_resp) begin
                rd_q  <= rd_n;
                err_q <= bad;
            end
        end
    end
    // Storage is not reset; a store commits only on a clean edge entering RESP
    always_ff @(posedge clk) begin
        if (!rst && go_resp && w && !r && !bad)
            for (int i = 0; i < 8; i++)
                if (i < int'(s)) mem[base + AW'(i)] <= d[8*i +: 8];
    end
    assign bus.req_ready  = state == IDLE;
    assign bus.resp_valid = state == RESP;
    assign bus.read_data  = state == RESP ? rd_q : '0;
    assign bus.err        = state == RESP && err_q;
endmodule

// File: tb/tb_datamem_responder.sv
// tb_datamem_responder: directed and randomized checks of datamem_responder against a byte-array reference model
module tb_datamem_responder;
    localparam int LATENCY = 2;
    localparam int DEPTH   = 1024;
    logic clk = 1'b0;
    logic rst;
    int vectors = 0;
    int miscompares = 0;
    logic [7:0] ref_mem [DEPTH];
    logic [63:0] got;
    datamem_if bus ();
    datamem_responder #(.LATENCY(LATENCY), .DEPTH_BYTES(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));
    always #5 clk = ~clk;
    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask
    function automatic logic ref_err(input logic w, input logic r, input logic [63:0] a, input logic [3:0] s);
        logic e;
        e = !(s inside {4'd1, 4'd2, 4'd4, 4'd8}) || (w && r);
        if (!e && a > 64'(DEPTH) - 64'(s)) e = 1'b1;
`ifdef DATAMEM_ALIGN_CHECK_EN
        if (!e && (a % 64'(s)) != 0) e = 1'b1;
`endif
        return e;
    endfunction
    task automatic do_req(input logic w, input logic r, input logic [63:0] a, input logic [63:0] d,
                          input logic [3:0] s, input int hold, output logic [63:0] rd);
        logic e;
        logic [63:0] exp_d;
        int n;
        e = ref_err(w, r, a, s);
        exp_d = '0;
        if (r && !w && !e)
            for (int i = 0; i < int'(s); i++) exp_d[8*i +: 8] = ref_mem[int'(a) + i];
        chk("req_ready_idle", 64'(bus.req_ready), 64'd1);
        bus.req_valid = 1'b1;
        bus.write_enable = w;
        bus.read_enable = r;
        bus.address = a;
        bus.write_data = d;
        bus.xfer_size = s;
        bus.resp_ready = 1'b0;
        @(posedge clk); #1;
        n = 1;
        while (!bus.resp_valid && n < 20) begin
            bus.req_valid = 1'($urandom_range(0, 1));
            bus.address = {$urandom, $urandom};
            bus.write_enable = 1'($urandom_range(0, 1));
            bus.read_enable = 1'($urandom_range(0, 1));
            bus.write_data = {$urandom, $urandom};
            bus.xfer_size = 4'($urandom_range(0, 15));
            @(posedge clk); #1;
            n++;
        end
        chk("latency", 64'(n), 64'(LATENCY));
        rd = bus.read_data;
        chk("read_data", bus.read_data, exp_d);
        chk("err", 64'(bus.err), 64'(e));
        chk("req_ready_busy", 64'(bus.req_ready), 64'd0);
        for (int h = 0; h < hold; h++) begin
            bus.req_valid = 1'b1;
            bus.address = 64'($urandom_range(0, DEPTH - 8));
            bus.write_enable = 1'b1;
            bus.read_enable = 1'b0;
            bus.xfer_size = 4'd8;
            @(posedge clk); #1;
            chk("hold_valid", 64'(bus.resp_valid), 64'd1);
            chk("hold_data", bus.read_data, exp_d);
            chk("hold_err", 64'(bus.err), 64'(e));
            chk("hold_ready", 64'(bus.req_ready), 64'd0);
        end
        bus.req_valid = 1'b0;
        bus.resp_ready = 1'b1;
        @(posedge clk); #1;
        bus.resp_ready = 1'b0;
        chk("post_valid", 64'(bus.resp_valid), 64'd0);
        chk("post_data", bus.read_data, 64'd0);
        chk("post_err", 64'(bus.err), 64'd0);
        chk("post_ready", 64'(bus.req_ready), 64'd1);
        if (w && !r && !e)
            for (int i = 0; i < int'(s); i++) ref_mem[int'(a) + i] = d[8*i +: 8];
    endtask
    initial begin
        logic [3:0] sizes [12] = '{4'd1, 4'd2, 4'd4, 4'd8, 4'd1, 4'd2, 4'd4, 4'd8, 4'd3, 4'd0, 4'd15, 4'd8};
        logic [63:0] a;
        int op;
        rst = 1'b1;
        bus.req_valid = 1'b0;
        bus.address = '0;
        bus.write_enable = 1'b0;
        bus.read_enable = 1'b0;
        bus.write_data = '0;
        bus.xfer_size = '0;
        bus.resp_ready = 1'b0;
        #1;
        chk("rst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("rst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("rst_read_data", bus.read_data, 64'd0);
        chk("rst_err", 64'(bus.err), 64'd0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        for (int k = 0; k < DEPTH / 8; k++) do_req(1'b1, 1'b0, 64'(k * 8), {$urandom, $urandom}, 4'd8, 0, got);
        do_req(1'b1, 1'b0, 64'd16, 64'h0123456789ABCDEF, 4'd8, 0, got);
        do_req(1'b0, 1'b1, 64'd16, 64'd0, 4'd8, 0, got);
        chk("store_load_16", got, 64'h0123456789ABCDEF);
        do_req(1'b0, 1'b1, 64'd17, 64'd0, 4'd2, 0, got);
        do_req(1'b1, 1'b0, 64'd16, '1, 4'd3, 0, got);
        do_req(1'b1, 1'b0, 64'd1020, '1, 4'd8, 0, got);
        do_req(1'b0, 1'b1, 64'd1016, 64'd0, 4'd8, 0, got);
        do_req(1'b1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFC, '1, 4'd8, 0, got);
        do_req(1'b1, 1'b1, 64'd40, '1, 4'd4, 0, got);
        do_req(1'b0, 1'b0, 64'd40, '1, 4'd4, 0, got);
        do_req(1'b0, 1'b1, 64'd40, 64'd0, 4'd8, 5, got);
        do_req(1'b1, 1'b0, 64'd1016, 64'h1122334455667788, 4'd8, 0, got);
        do_req(1'b0, 1'b1, 64'd1016, 64'd0, 4'd8, 0, got);
        chk("top_word", got, 64'h1122334455667788);
        bus.req_valid = 1'b1;
        bus.write_enable = 1'b1;
        bus.read_enable = 1'b0;
        bus.address = 64'd0;
        bus.write_data = 64'hDEADBEEF;
        bus.xfer_size = 4'd4;
        @(posedge clk); #1;
        bus.req_valid = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("arst_req_ready", 64'(bus.req_ready), 64'd1);
        chk("arst_resp_valid", 64'(bus.resp_valid), 64'd0);
        chk("arst_read_data", bus.read_data, 64'd0);
        chk("arst_err", 64'(bus.err), 64'd0);
        @(posedge clk); #1;
        rst = 1'b0;
        do_req(1'b0, 1'b1, 64'd0, 64'd0, 4'd4, 0, got);
        for (int k = 0; k < 250; k++) begin
            op = $urandom_range(0, 9);
            a = $urandom_range(0, 15) == 0 ? 64'hFFFF_FFFF_FFFF_FFF8 + 64'($urandom_range(0, 7))
                                            : 64'($urandom_range(0, DEPTH + 8));
            do_req(op < 4 || op == 8, (op >= 4 && op < 8) || op == 8, a, {$urandom, $urandom},
                   sizes[$urandom_range(0, 11)], $urandom_range(0, 3), got);
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
